// File: rtl/alu_pkg.sv
// Shared opcode constants, legal-opcode check and controller state encoding.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1000;
   localparam logic [3:0] OP_NAND = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // ALU result bundle: value plus zero and signed-overflow flags
   typedef struct packed {
      logic [3:0] r;
      logic       z;
      logic       o;
   } alu_res_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND: return 1'b1;
         default:                                                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arb_ctrl_alu.sv
// 4-bit two's complement ALU: AND/OR/ADD/SUB/SLT/NOR/NAND with zero and overflow flags.
// Latency: purely combinational.
// Backpressure: none; caller registers the result.
module alu_arb_ctrl_alu (
   input  logic [3:0]        op,
   input  logic [3:0]        a,
   input  logic [3:0]        b,
   output alu_pkg::alu_res_t res
);
   import alu_pkg::*;

   logic [3:0] sum;
   logic [3:0] diff;
   logic [3:0] r;
   logic       o;

   // Opcode decode; ADD/SUB wrap and flag signed overflow, other ops never overflow
   always_comb begin
      sum  = a + b;
      diff = a - b;
      r    = 4'b0000;
      o    = 1'b0;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_ADD: begin
            r = sum;
            o = (a[3] == b[3]) && (sum[3] != a[3]);
         end
         OP_SUB: begin
            r = diff;
            o = (a[3] != b[3]) && (diff[3] != a[3]);
         end
         OP_SLT:  r = {3'b000, ($signed(a) < $signed(b))};
         OP_NOR:  r = ~(a | b);
         OP_NAND: r = ~(a & b);
         default: r = 4'b0000;
      endcase
      res.r = r;
      res.z = (r == 4'b0000);
      res.o = o;
   end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Two-requester arbiter in front of a shared 4-bit ALU with a held response register.
// Latency: grant edge N -> rsp_valid visible after edge N+1; grants at least 3 cycles apart.
// Backpressure: response held stable while rsp_ready=0; no new grant until it is taken.
module alu_arb_ctrl #(
   parameter int RR = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_op,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_op,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [3:0] rsp_r,
   output logic       rsp_z,
   output logic       rsp_o,
   output logic       rsp_err
);
   import alu_pkg::*;

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic [3:0] op_q, op_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic       id_q, id_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_id_q, rsp_id_d;
   logic [3:0] rsp_r_q, rsp_r_d;
   logic       rsp_z_q, rsp_z_d;
   logic       rsp_o_q, rsp_o_d;
   logic       rsp_err_q, rsp_err_d;

   logic       gnt_any;
   logic       gnt_id;
   logic       gnt_en;
   alu_res_t   alu_res;

   // ALU sees only the captured operands, never the live request ports
   alu_arb_ctrl_alu u_alu (
      .op  (op_q),
      .a   (a_q),
      .b   (b_q),
      .res (alu_res)
   );

   // Pick a requester; on contention RR favours whoever did not win last time
   always_comb begin
      gnt_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         gnt_id = (RR != 0) ? ~last_q : 1'b0;
      end else begin
         gnt_id = req1_valid;
      end
      // rst_n gate keeps ready low during reset even though state already reads IDLE
      gnt_en     = rst_n && (state_q == ST_IDLE) && gnt_any;
      req0_ready = gnt_en & ~gnt_id;
      req1_ready = gnt_en &  gnt_id;
   end

   // Next-state and next-register values for the IDLE/EXEC/RESP sequence
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_r_d     = rsp_r_q;
      rsp_z_d     = rsp_z_q;
      rsp_o_d     = rsp_o_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_en) begin
               op_d    = gnt_id ? req1_op : req0_op;
               a_d     = gnt_id ? req1_a  : req0_a;
               b_d     = gnt_id ? req1_b  : req0_b;
               id_d    = gnt_id;
               last_d  = gnt_id;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            if (is_legal_op(op_q)) begin
               rsp_r_d   = alu_res.r;
               rsp_z_d   = alu_res.z;
               rsp_o_d   = alu_res.o;
               rsp_err_d = 1'b0;
            end else begin
               rsp_r_d   = 4'b0000;
               rsp_z_d   = 1'b0;
               rsp_o_d   = 1'b0;
               rsp_err_d = 1'b1;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         op_q        <= 4'b0000;
         a_q         <= 4'b0000;
         b_q         <= 4'b0000;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_r_q     <= 4'b0000;
         rsp_z_q     <= 1'b0;
         rsp_o_q     <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_r_q     <= rsp_r_d;
         rsp_z_q     <= rsp_z_d;
         rsp_o_q     <= rsp_o_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_r     = rsp_r_q;
   assign rsp_z     = rsp_z_q;
   assign rsp_o     = rsp_o_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed bench for alu_arb_ctrl: round-robin instance plus a fixed-priority twin on shared inputs.
// Latency: checks sampled 1-2 time units after each rising edge.
// Backpressure: exercised by holding rsp_ready low in RESP.
module tb_alu_arb_ctrl;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [3:0] req0_op, req0_a, req0_b;
   logic [3:0] req1_op, req1_a, req1_b;
   logic       rsp_ready;

   logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_o, rsp_err;
   logic [3:0] rsp_r;
   logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_z, fp_rsp_o, fp_rsp_err;
   logic [3:0] fp_rsp_r;

   int n_checks = 0;
   int n_fail   = 0;

   alu_arb_ctrl #(.RR(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
      .rsp_z(rsp_z), .rsp_o(rsp_o), .rsp_err(rsp_err)
   );

   alu_arb_ctrl #(.RR(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_r(fp_rsp_r),
      .rsp_z(fp_rsp_z), .rsp_o(fp_rsp_o), .rsp_err(fp_rsp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 4'd1; req0_b = 4'd1;
      req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 4'd2; req1_b = 4'd2;
      rsp_ready = 1'b0;
      step();
      step();
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
      end
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_z, rsp_o, rsp_err, rsp_r} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_rsp: got %b want 000000000", {rsp_valid, rsp_id, rsp_z, rsp_o, rsp_err, rsp_r});
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_add();
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 4'b0101; req0_b = 4'b0001;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL add_grant: got %b want 10", {req0_ready, req1_ready});
      end
      step();
      req0_valid = 1'b0;
      #1;
      n_checks++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL add_exec: valid/rdy0/rdy1 got %b want 000", {rsp_valid, req0_ready, req1_ready});
      end
      step();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_r, rsp_z, rsp_o, rsp_err} !== {1'b1, 1'b0, 4'b0110, 3'b000}) begin
         n_fail++;
         $display("FAIL add_rsp: v/id/r/z/o/err got %b %b %b %b%b%b want 1 0 0110 000",
                  rsp_valid, rsp_id, rsp_r, rsp_z, rsp_o, rsp_err);
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_drop: rsp_valid got %b want 0", rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic       exp_id;
      logic [3:0] exp_r;
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 4'd1; req0_b = 4'd1;
      req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 4'd3; req1_b = 4'd1;
      for (int i = 0; i < 4; i++) begin
         exp_id = i[0];
         exp_r  = exp_id ? 4'd4 : 4'd2;
         #1;
         n_checks++;
         if ({req0_ready, req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready}, exp_id ? 2'b01 : 2'b10);
         end
         n_checks++;
         if ({fp_req0_ready, fp_req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL fp_grant[%0d]: got %b want 10", i, {fp_req0_ready, fp_req1_ready});
         end
         step();
         step();
         n_checks++;
         if ({rsp_valid, rsp_id, rsp_r} !== {1'b1, exp_id, exp_r}) begin
            n_fail++;
            $display("FAIL rr_rsp[%0d]: v/id/r got %b %b %b want 1 %b %b", i, rsp_valid, rsp_id, rsp_r, exp_id, exp_r);
         end
         n_checks++;
         if ({fp_rsp_valid, fp_rsp_id, fp_rsp_r, fp_rsp_z, fp_rsp_o, fp_rsp_err} !== {1'b1, 1'b0, 4'd2, 3'b000}) begin
            n_fail++;
            $display("FAIL fp_rsp[%0d]: v/id/r/flags got %b %b %b %b%b%b want 1 0 0010 000",
                     i, fp_rsp_valid, fp_rsp_id, fp_rsp_r, fp_rsp_z, fp_rsp_o, fp_rsp_err);
         end
         step();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      rsp_ready  = 1'b0;
      req1_valid = 1'b1; req1_op = 4'b0110; req1_a = 4'b1110; req1_b = 4'b0111;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_grant: got %b want 01", {req0_ready, req1_ready});
      end
      step();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 4'd2; req0_b = 4'd3;
      step();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({rsp_valid, rsp_id, rsp_r, rsp_z, rsp_o, rsp_err, req0_ready, req1_ready}
             !== {1'b1, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: v/id/r/z/o/err/rdy got %b %b %b %b%b%b %b want 1 1 0111 010 00",
                     i, rsp_valid, rsp_id, rsp_r, rsp_z, rsp_o, rsp_err, {req0_ready, req1_ready});
         end
         step();
      end
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if ({rsp_valid, rsp_r, rsp_o, req0_ready} !== {1'b1, 4'b0111, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL bp_release: v/r/o/rdy0 got %b %b %b %b want 1 0111 1 0", rsp_valid, rsp_r, rsp_o, req0_ready);
      end
      step();
      n_checks++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin
         n_fail++;
         $display("FAIL bp_next_grant: v/rdy0/rdy1 got %b want 010", {rsp_valid, req0_ready, req1_ready});
      end
      req0_valid = 1'b0;
   endtask

   task automatic test_illegal_op();
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_op = 4'b0011; req0_a = 4'd5; req0_b = 4'd5;
      step();
      req0_valid = 1'b0;
      step();
      n_checks++;
      if ({rsp_valid, rsp_r, rsp_z, rsp_o, rsp_err} !== {1'b1, 4'b0000, 3'b001}) begin
         n_fail++;
         $display("FAIL illegal_rsp: v/r/z/o/err got %b %b %b%b%b want 1 0000 001", rsp_valid, rsp_r, rsp_z, rsp_o, rsp_err);
      end
      step();
      req1_valid = 1'b1; req1_op = 4'b0111; req1_a = 4'b0001; req1_b = 4'b0011;
      step();
      req1_valid = 1'b0;
      step();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_r, rsp_z, rsp_o, rsp_err} !== {1'b1, 1'b1, 4'b0001, 3'b000}) begin
         n_fail++;
         $display("FAIL slt_after_err: v/id/r/z/o/err got %b %b %b %b%b%b want 1 1 0001 000",
                  rsp_valid, rsp_id, rsp_r, rsp_z, rsp_o, rsp_err);
      end
      step();
   endtask

   task automatic test_op_table();
      // {op, a, b, r, z, o, err}
      logic [18:0] vec [12];
      logic [18:0] v;
      vec[0]  = {4'b0000, 4'b1100, 4'b1010, 4'b1000, 3'b000};
      vec[1]  = {4'b0001, 4'b0000, 4'b0000, 4'b0000, 3'b100};
      vec[2]  = {4'b1000, 4'b1100, 4'b0011, 4'b0000, 3'b100};
      vec[3]  = {4'b1101, 4'b1010, 4'b0101, 4'b1111, 3'b000};
      vec[4]  = {4'b0010, 4'b0111, 4'b0001, 4'b1000, 3'b010};
      vec[5]  = {4'b0010, 4'b1111, 4'b0001, 4'b0000, 3'b100};
      vec[6]  = {4'b0110, 4'b0011, 4'b0011, 4'b0000, 3'b100};
      vec[7]  = {4'b0111, 4'b1000, 4'b0111, 4'b0001, 3'b000};
      vec[8]  = {4'b0111, 4'b0111, 4'b1000, 4'b0000, 3'b100};
      vec[9]  = {4'b1111, 4'b0101, 4'b0101, 4'b0000, 3'b001};
      vec[10] = {4'b0110, 4'b1000, 4'b0001, 4'b0111, 3'b010};
      vec[11] = {4'b0001, 4'b1001, 4'b0100, 4'b1101, 3'b000};
      rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         v = vec[i];
         req0_valid = 1'b1; req0_op = v[18:15]; req0_a = v[14:11]; req0_b = v[10:7];
         step();
         req0_valid = 1'b0;
         step();
         n_checks++;
         if ({rsp_valid, rsp_r, rsp_z, rsp_o, rsp_err} !== {1'b1, v[6:0]}) begin
            n_fail++;
            $display("FAIL op_table[%0d]: op %b v/r/z/o/err got %b %b %b%b%b want 1 %b %b",
                     i, v[18:15], rsp_valid, rsp_r, rsp_z, rsp_o, rsp_err, v[6:3], v[2:0]);
         end
         step();
      end
   endtask

   task automatic test_reset_in_exec();
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 4'd1; req0_b = 4'd2;
      step();
      req0_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_exec_abort: v/rdy0/rdy1 got %b want 000", {rsp_valid, req0_ready, req1_ready});
      end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_norsp[%0d]: rsp_valid got %b want 0", i, rsp_valid);
         end
      end
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL rst_exec_regrant: got %b want 10", {req0_ready, req1_ready});
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_op = 4'd0; req0_a = 4'd0; req0_b = 4'd0;
      req1_valid = 1'b0; req1_op = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
      rsp_ready = 1'b0;
      test_reset();
      test_add();
      apply_reset();
      test_round_robin();
      test_backpressure();
      test_illegal_op();
      test_op_table();
      test_reset_in_exec();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
